// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Instruction-fetch stage of the pipelined 32-bit core. Owns the PC, drives
// the single-cycle instruction-memory read port and loads the IF/ID pipeline
// register consumed by the decode stage. Decode may freeze the PC and/or the
// IF/ID register (pcWrite / ifIdWrite) and may redirect the PC (branchTaken).
//
// A word that arrives while decode is stalling is parked in a hold register
// (state HELD) so the same address is never read twice.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pcWrite, ifIdWrite  hazard controls from decode (0 = hold)
//   branchTaken,
//   branchTarget        redirect request and address (bits [1:0] ignored)
//   imemAddr, imemRead  instruction-memory request (imemAddr is always PC)
//   imemData, imemReady read data, valid for the current imemAddr when ready
//   programCounterOut   PC+4 of the instruction held in IF/ID
//   instruction         IF/ID instruction word
//   instructionValid    1 = real instruction in IF/ID, 0 = bubble
//
// Optional build macro FETCH_STATS_EN adds two free-running 32-bit counters:
//   fetchCount  edges at which IF/ID loaded a valid instruction
//   stallCount  edges at which an available word was held due to a stall
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcWrite,
    input  logic        ifIdWrite,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] imemAddr,
    output logic        imemRead,
    input  logic [31:0] imemData,
    input  logic        imemReady,
    output logic [31:0] programCounterOut,
    output logic [31:0] instruction,
    output logic        instructionValid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetchCount,
    output logic [31:0] stallCount
`endif
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HELD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pco_q, pco_d;
    logic        valid_q, valid_d;

    logic        word_avail_s;
    logic [31:0] word_s;
    logic [31:0] pc_plus4_s;
    logic        load_s;
    logic        stall_s;
    logic        imem_read_s;

    // The two low target bits are architecturally zero and deliberately dropped.
    logic        unused_ok_s;
    assign unused_ok_s = &{1'b0, branchTarget[1:0]};

    // Source of the current word: live memory data while fetching, parked copy otherwise.
    always_comb begin
        word_avail_s = 1'b0;
        word_s       = imemData;
        if (state_q == ST_HELD) begin
            word_avail_s = 1'b1;
            word_s       = hold_q;
        end else begin
            word_avail_s = imemReady;
            word_s       = imemData;
        end
    end

    // Modulo-2^32 increment; wraps 0xFFFF_FFFC to 0 with no flag.
    assign pc_plus4_s = pc_q + 32'd4;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values, in redirect > load > stall > wait priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        pco_d   = pco_q;
        valid_d = valid_q;
        load_s  = 1'b0;
        stall_s = 1'b0;
        if (branchTaken) begin
            // Redirect wins over hazard holds; any fetched/held word is discarded.
            pc_d    = {branchTarget[31:2], 2'b00};
            state_d = ST_FETCH;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (word_avail_s && pcWrite && ifIdWrite) begin
            load_s  = 1'b1;
            instr_d = word_s;
            pco_d   = pc_plus4_s;
            valid_d = 1'b1;
            pc_d    = pc_plus4_s;
            state_d = ST_FETCH;
        end else if (word_avail_s) begin
            // Decode is stalling: park the word so it is not read again.
            stall_s = 1'b1;
            if (state_q == ST_FETCH) begin
                hold_d  = imemData;
                state_d = ST_HELD;
            end else begin
                state_d = ST_HELD;
            end
        end else begin
            // Memory wait state: inject a bubble only if IF/ID is allowed to move.
            if (ifIdWrite) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
    end

    // Memory read request is a pure function of the registered state.
    always_comb begin
        imem_read_s = 1'b1;
        case (state_q)
            ST_FETCH: imem_read_s = 1'b1;
            ST_HELD:  imem_read_s = 1'b0;
            default:  imem_read_s = 1'b1;
        endcase
    end

    // PC, hold register and IF/ID pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            hold_q  <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            pco_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            valid_q <= valid_d;
        end
    end

    assign imemAddr          = pc_q;
    assign imemRead          = imem_read_s;
    assign programCounterOut = pco_q;
    assign instruction       = instr_q;
    assign instructionValid  = valid_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Delivery and stall event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            if (load_s) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                fetch_cnt_q <= fetch_cnt_q;
            end
            if (stall_s) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign stallCount = stall_cnt_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = &{1'b0, load_s, stall_s};
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// Self-checking bench for instruction_fetch. A behavioural model of the fetch
// stage predicts the outputs after every clock edge; predictions are queued
// when stimulus is applied and popped/compared after the edge. Directed
// spot checks with fixed constants cover the key scenarios as well.
// Memory returns addr | 0xA000_0000; while the DUT is parked (HELD) the memory
// returns garbage so a re-read of a held word would be visible.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] imemAddr;
    logic        imemRead;
    logic [31:0] imemData;
    logic        imemReady;
    logic [31:0] programCounterOut;
    logic [31:0] instruction;
    logic        instructionValid;
    logic        corrupt;
`ifdef FETCH_STATS_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    instruction_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pcWrite          (pcWrite),
        .ifIdWrite        (ifIdWrite),
        .branchTaken      (branchTaken),
        .branchTarget     (branchTarget),
        .imemAddr         (imemAddr),
        .imemRead         (imemRead),
        .imemData         (imemData),
        .imemReady        (imemReady),
        .programCounterOut(programCounterOut),
        .instruction      (instruction),
        .instructionValid (instructionValid)
`ifdef FETCH_STATS_EN
        ,
        .fetchCount       (fetchCount),
        .stallCount       (stallCount)
`endif
    );

    assign imemData = corrupt ? 32'hDEAD_BEEF : (imemAddr | 32'hA000_0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] ins;
        logic [31:0] pco;
        logic        vld;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [31:0] m_pc, m_hold, m_ins, m_pco, m_fc, m_sc;
    logic        m_held, m_vld;

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_hold = 32'h0;
        m_held = 1'b0;
        m_ins  = NOP_INSTR;
        m_pco  = 32'h0;
        m_vld  = 1'b0;
        m_fc   = 32'h0;
        m_sc   = 32'h0;
    endtask

    task automatic check_counters(input logic [31:0] fc, input logic [31:0] sc);
`ifdef FETCH_STATS_EN
        check_eq("fetchCount", fetchCount, fc);
        check_eq("stallCount", stallCount, sc);
`endif
    endtask

    // One clock: apply inputs, predict, wait for the edge, compare on the falling edge.
    task automatic step(input logic pw, input logic iw, input logic br,
                        input logic [31:0] bt, input logic rdy);
        logic        avail;
        logic [31:0] w;
        exp_t        e;
        pcWrite      = pw;
        ifIdWrite    = iw;
        branchTaken  = br;
        branchTarget = bt;
        imemReady    = rdy;
        corrupt      = m_held;
        avail = m_held || rdy;
        w     = m_held ? m_hold : (m_pc | 32'hA000_0000);
        if (br) begin
            m_pc   = bt & 32'hFFFF_FFFC;
            m_held = 1'b0;
            m_ins  = NOP_INSTR;
            m_vld  = 1'b0;
        end else if (avail && pw && iw) begin
            m_ins  = w;
            m_pco  = m_pc + 32'd4;
            m_vld  = 1'b1;
            m_pc   = m_pc + 32'd4;
            m_held = 1'b0;
            m_fc   = m_fc + 32'd1;
        end else if (avail) begin
            if (!m_held) begin
                m_hold = w;
                m_held = 1'b1;
            end
            m_sc = m_sc + 32'd1;
        end else if (iw) begin
            m_ins = NOP_INSTR;
            m_vld = 1'b0;
        end
        e.addr = m_pc;
        e.rd   = ~m_held;
        e.ins  = m_ins;
        e.pco  = m_pco;
        e.vld  = m_vld;
        e.fc   = m_fc;
        e.sc   = m_sc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq("imemAddr", imemAddr, e.addr);
            check_eq("imemRead", {31'b0, imemRead}, {31'b0, e.rd});
            check_eq("instruction", instruction, e.ins);
            check_eq("pcOut", programCounterOut, e.pco);
            check_eq("valid", {31'b0, instructionValid}, {31'b0, e.vld});
            check_counters(e.fc, e.sc);
        end
    endtask

    // Asynchronous reset pulse away from the clock edge; outputs must clear immediately.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_addr", imemAddr, 32'h0000_0000);
        check_eq("rst_read", {31'b0, imemRead}, 32'd1);
        check_eq("rst_instr", instruction, 32'h0000_0000);
        check_eq("rst_pcout", programCounterOut, 32'h0000_0000);
        check_eq("rst_valid", {31'b0, instructionValid}, 32'd0);
        check_counters(32'h0, 32'h0);
        model_reset();
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        pcWrite      = 1'b1;
        ifIdWrite    = 1'b1;
        branchTaken  = 1'b0;
        branchTarget = 32'h0;
        imemReady    = 1'b0;
        corrupt      = 1'b0;
        model_reset();
        @(negedge clk);
        async_reset();

        // Zero-wait streaming: third edge delivers the word at 0x8.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("stream_instr", instruction, 32'hA000_0008);
        check_eq("stream_pcout", programCounterOut, 32'h0000_000C);
        check_eq("stream_valid", {31'b0, instructionValid}, 32'd1);

        // Memory wait states at pc=0x4.
        async_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("ws_bubble", {31'b0, instructionValid}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("ws_addr", imemAddr, 32'h0000_0004);
        check_eq("ws_nop", instruction, NOP_INSTR);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("ws_instr", instruction, 32'hA000_0004);
        check_eq("ws_pcout", programCounterOut, 32'h0000_0008);

        // Decode stall at pc=0x8: word parked, no re-read, delivered on release.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stall_read", {31'b0, imemRead}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("stall_frozen", instruction, 32'hA000_0004);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("rel_instr", instruction, 32'hA000_0008);
        check_eq("rel_addr", imemAddr, 32'h0000_000C);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("pre_rst_pc", imemAddr, 32'h0000_0010);

        // Asynchronous reset mid-stream at pc=0x10.
        async_reset();

        // Branch while HELD with ifIdWrite=0 drops the held word.
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0043, 1'b1);
        check_eq("br_addr", imemAddr, 32'h0000_0040);
        check_eq("br_bubble", {31'b0, instructionValid}, 32'd0);
        check_eq("br_read", {31'b0, imemRead}, 32'd1);

        // PC wrap from 0xFFFF_FFFC.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("wrap_addr", imemAddr, 32'h0000_0000);
        check_eq("wrap_pcout", programCounterOut, 32'h0000_0000);

        // Statistics: 5 deliveries plus 2 stall edges.
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_STATS_EN
        check_eq("stats_fetch", fetchCount, 32'd5);
        check_eq("stats_stall", stallCount, 32'd2);
`endif
        async_reset();

        // Randomised mix of stalls, wait states and redirects.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
